// File: rtl/nios2_pkg.sv
// Shared types and constants for the Nios II instruction-fetch block.
// Holds the fetch FSM state encoding, the NOP word and the fetch-counter width.
package nios2_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [31:0] NOP   = 32'h0;
   localparam int          CNT_W = 16;

endpackage

// File: rtl/nios2_imem.sv
// Instruction store: one write port, one registered read port with synchronous clear.
// Read data appears one cycle after rd_en; optional per-word even parity (NIOS2_IFETCH_PARITY_EN).
module nios2_imem
   import nios2_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic              rd_clr,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
`ifdef NIOS2_IFETCH_PARITY_EN
   ,
   output logic              rd_par_ok
`endif
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;

   // Addresses wrap modulo DEPTH by dropping the upper bits.
   assign wr_idx = wr_addr[IDX_W-1:0];
   assign rd_idx = rd_addr[IDX_W-1:0];

   // Storage is deliberately not reset so a loaded program survives reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        rd_data <= DATA_W'(NOP);
      else if (rd_clr) rd_data <= DATA_W'(NOP);
      else if (rd_en)  rd_data <= mem[rd_idx];
   end

`ifdef NIOS2_IFETCH_PARITY_EN
   logic par_mem [DEPTH];
   logic rd_par;

   always_ff @(posedge clk) begin
      if (wr_en) par_mem[wr_idx] <= ^wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        rd_par <= 1'b0;
      else if (rd_clr) rd_par <= 1'b0;
      else if (rd_en)  rd_par <= par_mem[rd_idx];
   end

   assign rd_par_ok = ((^rd_data) == rd_par);
`endif

endmodule

// File: rtl/nios2_ifetch.sv
// Instruction fetch front end: program load, then 1-cycle fetch of mem[pc_i] for the core.
// No backpressure; enable stalls (HOLD), flush_i kills to NOP; parity option NIOS2_IFETCH_PARITY_EN.
module nios2_ifetch
   import nios2_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              flush_i,
   input  logic              load_we_i,
   input  logic [ADDR_W-1:0] load_addr_i,
   input  logic [DATA_W-1:0] load_data_i,
   output logic [DATA_W-1:0] inst_fetch_o,
   output logic              inst_valid_o,
   output logic              load_err_o,
   output logic [CNT_W-1:0]  fetch_cnt_o,
   output logic              par_err_o
);

   state_t state;
   logic   active;
   logic   wr_ok;
   logic   wr_rej;
   logic   do_fetch;
   logic   do_clr;

   assign active   = (state == RUN) || (state == HOLD);
   assign wr_ok    = load_we_i && !enable && ((state == IDLE) || (state == HOLD));
   assign wr_rej   = load_we_i && (enable || (state == RUN));
   // Flush outranks enable: a killed cycle neither fetches nor counts.
   assign do_fetch = active && enable && !flush_i;
   assign do_clr   = active && flush_i;

`ifdef NIOS2_IFETCH_PARITY_EN
   logic rd_par_ok;
`endif

   nios2_imem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_imem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_ok),
      .wr_addr (load_addr_i),
      .wr_data (load_data_i),
      .rd_en   (do_fetch),
      .rd_clr  (do_clr),
      .rd_addr (pc_i),
      .rd_data (inst_fetch_o)
`ifdef NIOS2_IFETCH_PARITY_EN
      ,
      .rd_par_ok (rd_par_ok)
`endif
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         inst_valid_o <= 1'b0;
         load_err_o   <= 1'b0;
         fetch_cnt_o  <= '0;
      end else begin
         inst_valid_o <= do_fetch;
         load_err_o   <= wr_rej;
         if (do_fetch && (fetch_cnt_o != {CNT_W{1'b1}}))
            fetch_cnt_o <= fetch_cnt_o + 1'b1;
         case (state)
            IDLE: if (enable) state <= RUN;
            RUN:  if (!flush_i && !enable) state <= HOLD;
            HOLD: begin
               if (enable)         state <= RUN;
               else if (load_we_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef NIOS2_IFETCH_PARITY_EN
   // Sticky: the bad word is still delivered, only the flag records it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                             par_err_o <= 1'b0;
      else if (inst_valid_o && !rd_par_ok)  par_err_o <= 1'b1;
   end
`else
   assign par_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_nios2_ifetch.sv
// Self-checking bench for nios2_ifetch: scoreboard of expected fetch words plus per-scenario checks.
`timescale 1ns/1ps
module tb_nios2_ifetch;
   import nios2_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [7:0]  pc_i;
   logic        flush_i;
   logic        load_we_i;
   logic [7:0]  load_addr_i;
   logic [31:0] load_data_i;
   logic [31:0] inst_fetch_o;
   logic        inst_valid_o;
   logic        load_err_o;
   logic [15:0] fetch_cnt_o;
   logic        par_err_o;

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [31:0] exp_q [$];
   logic [31:0] model [256];
   logic [31:0] sb_exp;
   bit          sb_on = 1'b1;

   always #5 clk = ~clk;

   nios2_ifetch #(.ADDR_W(8), .DATA_W(32), .DEPTH(256)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .pc_i         (pc_i),
      .flush_i      (flush_i),
      .load_we_i    (load_we_i),
      .load_addr_i  (load_addr_i),
      .load_data_i  (load_data_i),
      .inst_fetch_o (inst_fetch_o),
      .inst_valid_o (inst_valid_o),
      .load_err_o   (load_err_o),
      .fetch_cnt_o  (fetch_cnt_o),
      .par_err_o    (par_err_o)
   );

   // Every valid word the DUT presents must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst && sb_on && inst_valid_o) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL sb_extra: got valid word %h, expected no output", inst_fetch_o);
         end else begin
            sb_exp = exp_q.pop_front();
            if (inst_fetch_o !== sb_exp) begin
               n_fails++;
               $display("FAIL sb_word: got %h, expected %h", inst_fetch_o, sb_exp);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(negedge clk);
   endtask

   task automatic load_word(input logic [7:0] a, input logic [31:0] d);
      enable = 1'b0; load_we_i = 1'b1; load_addr_i = a; load_data_i = d;
      model[a] = d;
      step();
      load_we_i = 1'b0;
   endtask

   task automatic fetch(input logic [7:0] a);
      enable = 1'b1; flush_i = 1'b0; pc_i = a;
      if (sb_on) exp_q.push_back(model[a]);
      step();
   endtask

   task automatic test_reset;
      rst = 1'b0; enable = 1'b0; flush_i = 1'b0; load_we_i = 1'b0;
      pc_i = '0; load_addr_i = '0; load_data_i = '0;
      step(); step();
      n_checks += 6;
      if (inst_fetch_o !== 32'h0) begin n_fails++; $display("FAIL rst_fetch: got %h, expected 0", inst_fetch_o); end
      if (inst_valid_o !== 1'b0) begin n_fails++; $display("FAIL rst_valid: got %b, expected 0", inst_valid_o); end
      if (load_err_o !== 1'b0) begin n_fails++; $display("FAIL rst_err: got %b, expected 0", load_err_o); end
      if (fetch_cnt_o !== 16'h0) begin n_fails++; $display("FAIL rst_cnt: got %h, expected 0", fetch_cnt_o); end
      if (par_err_o !== 1'b0) begin n_fails++; $display("FAIL rst_par: got %b, expected 0", par_err_o); end
      if (dut.state !== IDLE) begin n_fails++; $display("FAIL rst_state: got %0d, expected IDLE", dut.state); end
      rst = 1'b1;
   endtask

   task automatic test_load_fetch;
      logic [7:0] pcs [4];
      pcs = '{8'd255, 8'd7, 8'd2, 8'd4};
      load_word(8'd0, 32'h3A);           load_word(8'd1, 32'h31);
      load_word(8'd2, 32'hA5A5_0F0F);    load_word(8'd3, 32'h0000_0001);
      load_word(8'd4, 32'hFFFF_FFFF);    load_word(8'd5, 32'h8000_0000);
      load_word(8'd6, 32'h1357_9BDF);    load_word(8'd7, 32'hCAFE_F00D);
      load_word(8'd255, 32'h0BAD_BEEF);
      enable = 1'b1; pc_i = 8'd0;
      step();
      n_checks++;
      if (inst_valid_o !== 1'b0) begin n_fails++; $display("FAIL idle_no_read: got valid %b, expected 0", inst_valid_o); end
      fetch(8'd0);
      n_checks += 2;
      if (inst_fetch_o !== 32'h3A) begin n_fails++; $display("FAIL fetch0: got %h, expected 3a", inst_fetch_o); end
      if (inst_valid_o !== 1'b1) begin n_fails++; $display("FAIL fetch0_valid: got %b, expected 1", inst_valid_o); end
      fetch(8'd1);
      n_checks += 2;
      if (inst_fetch_o !== 32'h31) begin n_fails++; $display("FAIL fetch1: got %h, expected 31", inst_fetch_o); end
      if (fetch_cnt_o !== 16'd2) begin n_fails++; $display("FAIL cnt2: got %0d, expected 2", fetch_cnt_o); end
      for (int i = 0; i < 4; i++) fetch(pcs[i]);
      n_checks++;
      if (fetch_cnt_o !== 16'd6) begin n_fails++; $display("FAIL cnt6: got %0d, expected 6", fetch_cnt_o); end
   endtask

   task automatic test_hold;
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks += 2;
         if (inst_fetch_o !== 32'hFFFF_FFFF) begin n_fails++; $display("FAIL hold_data%0d: got %h, expected ffffffff", i, inst_fetch_o); end
         if (inst_valid_o !== 1'b0) begin n_fails++; $display("FAIL hold_valid%0d: got %b, expected 0", i, inst_valid_o); end
      end
      n_checks += 2;
      if (dut.state !== HOLD) begin n_fails++; $display("FAIL hold_state: got %0d, expected HOLD", dut.state); end
      if (fetch_cnt_o !== 16'd6) begin n_fails++; $display("FAIL hold_cnt: got %0d, expected 6", fetch_cnt_o); end
      fetch(8'd3);
      n_checks += 2;
      if (inst_valid_o !== 1'b1) begin n_fails++; $display("FAIL resume_valid: got %b, expected 1", inst_valid_o); end
      if (fetch_cnt_o !== 16'd7) begin n_fails++; $display("FAIL resume_cnt: got %0d, expected 7", fetch_cnt_o); end
   endtask

   task automatic test_flush;
      enable = 1'b1; flush_i = 1'b1; pc_i = 8'd5;
      step();
      n_checks += 3;
      if (inst_fetch_o !== 32'h0) begin n_fails++; $display("FAIL flush_nop: got %h, expected 0", inst_fetch_o); end
      if (inst_valid_o !== 1'b0) begin n_fails++; $display("FAIL flush_valid: got %b, expected 0", inst_valid_o); end
      if (fetch_cnt_o !== 16'd7) begin n_fails++; $display("FAIL flush_cnt: got %0d, expected 7", fetch_cnt_o); end
      fetch(8'd5);
      enable = 1'b0;
      step();
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      n_checks += 2;
      if (inst_fetch_o !== 32'h0) begin n_fails++; $display("FAIL hold_flush_nop: got %h, expected 0", inst_fetch_o); end
      if (dut.state !== HOLD) begin n_fails++; $display("FAIL hold_flush_state: got %0d, expected HOLD", dut.state); end
      fetch(8'd6);
      n_checks++;
      if (fetch_cnt_o !== 16'd9) begin n_fails++; $display("FAIL flush_resume_cnt: got %0d, expected 9", fetch_cnt_o); end
   endtask

   task automatic test_load_err;
      load_we_i = 1'b1; load_addr_i = 8'd0; load_data_i = 32'hDEAD_BEEF;
      fetch(8'd7);
      load_we_i = 1'b0;
      n_checks++;
      if (load_err_o !== 1'b1) begin n_fails++; $display("FAIL run_load_err: got %b, expected 1", load_err_o); end
      fetch(8'd0);
      n_checks += 2;
      if (load_err_o !== 1'b0) begin n_fails++; $display("FAIL err_pulse_len: got %b, expected 0", load_err_o); end
      if (inst_fetch_o !== 32'h3A) begin n_fails++; $display("FAIL run_load_ignored: got %h, expected 3a", inst_fetch_o); end
      enable = 1'b0;
      step();
      load_word(8'd6, 32'h1234_5678);
      n_checks += 2;
      if (dut.state !== IDLE) begin n_fails++; $display("FAIL hold_write_state: got %0d, expected IDLE", dut.state); end
      if (load_err_o !== 1'b0) begin n_fails++; $display("FAIL hold_write_err: got %b, expected 0", load_err_o); end
      enable = 1'b1; load_we_i = 1'b1; load_addr_i = 8'd7; load_data_i = 32'h0;
      step();
      load_we_i = 1'b0;
      n_checks++;
      if (load_err_o !== 1'b1) begin n_fails++; $display("FAIL idle_en_load_err: got %b, expected 1", load_err_o); end
      fetch(8'd6);
      n_checks++;
      if (inst_fetch_o !== 32'h1234_5678) begin n_fails++; $display("FAIL hold_write_read: got %h, expected 12345678", inst_fetch_o); end
      fetch(8'd7);
      n_checks++;
      if (fetch_cnt_o !== 16'd13) begin n_fails++; $display("FAIL err_cnt: got %0d, expected 13", fetch_cnt_o); end
   endtask

   task automatic test_reset_mid;
      enable = 1'b0;
      #2 rst = 1'b0;
      #1;
      n_checks += 4;
      if (inst_fetch_o !== 32'h0) begin n_fails++; $display("FAIL async_fetch: got %h, expected 0", inst_fetch_o); end
      if (inst_valid_o !== 1'b0) begin n_fails++; $display("FAIL async_valid: got %b, expected 0", inst_valid_o); end
      if (fetch_cnt_o !== 16'h0) begin n_fails++; $display("FAIL async_cnt: got %h, expected 0", fetch_cnt_o); end
      if (dut.state !== IDLE) begin n_fails++; $display("FAIL async_state: got %0d, expected IDLE", dut.state); end
      step();
      rst = 1'b1;
      enable = 1'b1;
      step();
      fetch(8'd0);
      n_checks++;
      if (inst_fetch_o !== 32'h3A) begin n_fails++; $display("FAIL survive0: got %h, expected 3a", inst_fetch_o); end
      fetch(8'd1);
      n_checks += 2;
      if (inst_fetch_o !== 32'h31) begin n_fails++; $display("FAIL survive1: got %h, expected 31", inst_fetch_o); end
      if (fetch_cnt_o !== 16'd2) begin n_fails++; $display("FAIL survive_cnt: got %0d, expected 2", fetch_cnt_o); end
   endtask

   task automatic test_saturate;
      enable = 1'b0;
      step();
      sb_on = 1'b0;
      for (int i = 0; i < 65532; i++) fetch(8'(i % 8));
      enable = 1'b0;
      step();
      sb_on = 1'b1;
      n_checks++;
      if (fetch_cnt_o !== 16'hFFFE) begin n_fails++; $display("FAIL cnt_fffe: got %h, expected fffe", fetch_cnt_o); end
      for (int i = 0; i < 3; i++) begin
         fetch(8'(2 + i));
         n_checks++;
         if (fetch_cnt_o !== 16'hFFFF) begin n_fails++; $display("FAIL cnt_sat%0d: got %h, expected ffff", i, fetch_cnt_o); end
      end
      enable = 1'b0;
      step();
   endtask

`ifdef NIOS2_IFETCH_PARITY_EN
   task automatic test_parity;
      n_checks++;
      if (par_err_o !== 1'b0) begin n_fails++; $display("FAIL par_clean: got %b, expected 0", par_err_o); end
      dut.u_imem.par_mem[5] = ~dut.u_imem.par_mem[5];
      fetch(8'd5);
      n_checks++;
      if (inst_valid_o !== 1'b1) begin n_fails++; $display("FAIL par_word_valid: got %b, expected 1", inst_valid_o); end
      fetch(8'd0);
      n_checks++;
      if (par_err_o !== 1'b1) begin n_fails++; $display("FAIL par_set: got %b, expected 1", par_err_o); end
      enable = 1'b0;
      step(); step();
      n_checks++;
      if (par_err_o !== 1'b1) begin n_fails++; $display("FAIL par_sticky: got %b, expected 1", par_err_o); end
      rst = 1'b0;
      step();
      n_checks++;
      if (par_err_o !== 1'b0) begin n_fails++; $display("FAIL par_reset: got %b, expected 0", par_err_o); end
      rst = 1'b1;
      step();
   endtask
`else
   task automatic test_parity;
      n_checks++;
      if (par_err_o !== 1'b0) begin n_fails++; $display("FAIL par_tied: got %b, expected 0", par_err_o); end
   endtask
`endif

   initial begin
      test_reset();
      test_load_fetch();
      test_hold();
      test_flush();
      test_load_err();
      test_reset_mid();
      test_saturate();
      test_parity();
      n_checks++;
      if (exp_q.size() != 0) begin n_fails++; $display("FAIL sb_missing: got %0d outstanding words, expected 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
